// File: rtl/ss_xfer_fifo.sv
// 64-bit first-word-fall-through staging FIFO between the memory-read and memory-write
// scatter-gather engines; paces both engines from occupancy and job phase.
module ss_xfer_fifo #(
  parameter int AW    = 4,
  parameter int BURST = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          go,
  input  logic          ss_done,
  input  logic          src_xfer,
  input  logic          src_last,
  input  logic [31:0]   src_dat_lo,
  input  logic [31:0]   src_dat_hi,
  output logic          src_start,
  output logic          src_stop,
  output logic          src_end,
  input  logic          dst_xfer,
  input  logic          dst_last,
  output logic [31:0]   dst_dat_lo,
  output logic [31:0]   dst_dat_hi,
  output logic          dst_start,
  output logic          dst_stop,
  output logic          dst_end,
  output logic [AW:0]   fifo_cnt,
  output logic [15:0]   xfer_cnt,
  output logic          job_done,
  output logic [1:0]    err
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] BURST_C = (AW+1)'(BURST);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);
  localparam logic [AW:0] ZERO_C  = '0;

  localparam logic [2:0] F_IDLE  = 3'd0;
  localparam logic [2:0] F_RUN   = 3'd1;
  localparam logic [2:0] F_DRAIN = 3'd2;
  localparam logic [2:0] F_DONE  = 3'd3;
  localparam logic [2:0] F_ERR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   xfer_q, xfer_d;
  logic [1:0]    err_q, err_d;
  logic [63:0]   mem_q [DEPTH];

  logic in_run, in_drain, active, full, empty;
  logic push_ok, pop_ok, overrun, underrun;

  assign in_run   = (state_q == F_RUN);
  assign in_drain = (state_q == F_DRAIN);
  assign active   = in_run || in_drain;
  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == ZERO_C);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign pop_ok   = active && !ss_done && dst_xfer && !empty;
  assign push_ok  = in_run && !ss_done && src_xfer && (!full || pop_ok);
  assign overrun  = in_run && src_xfer && full && !dst_xfer;
  assign underrun = active && dst_xfer && empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    xfer_d   = xfer_q;
    err_d    = err_q;
    case (state_q)
      F_IDLE: begin
        if (go) begin
          state_d  = F_RUN;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          xfer_d   = '0;
          err_d    = '0;
        end
      end
      F_RUN, F_DRAIN: begin
        if (ss_done) begin
          state_d  = F_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          err_d    = '0;
        end else begin
          if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
          if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            xfer_d   = xfer_q + 16'd1;
          end
          case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + ONE_C;
            2'b01:   cnt_d = cnt_q - ONE_C;
            default: cnt_d = cnt_q;
          endcase

          if (overrun || underrun) begin
            err_d[0] = 1'b1;
            state_d  = F_ERR;
          end else if (in_run) begin
            if (dst_xfer && dst_last) begin
              err_d[1] = 1'b1;
              state_d  = F_ERR;
            end else if (src_xfer && src_last) begin
              state_d = F_DRAIN;
            end
          end else begin
            // Draining: the source chain has ended, the destination must consume exactly the rest.
            if (src_xfer) begin
              err_d[1] = 1'b1;
              state_d  = F_ERR;
            end else if (dst_xfer && dst_last) begin
              if (cnt_d == ZERO_C) begin
                state_d = F_DONE;
              end else begin
                err_d[1] = 1'b1;
                state_d  = F_ERR;
              end
            end else if (!dst_xfer && empty) begin
              err_d[1] = 1'b1;
              state_d  = F_DONE;
            end
          end
        end
      end
      F_DONE, F_ERR: begin
        if (ss_done) begin
          state_d  = F_IDLE;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
          err_d    = '0;
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= F_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      xfer_q   <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      xfer_q   <= xfer_d;
      err_q    <= err_d;
    end
  end

  // NOTE: the storage array has no reset; the head is masked to zero while empty instead.
  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= {src_dat_hi, src_dat_lo};
  end

  logic [63:0] head;
  assign head       = empty ? 64'd0 : mem_q[rd_ptr_q];
  assign dst_dat_lo = head[31:0];
  assign dst_dat_hi = head[63:32];

  assign src_start = in_run && ((DEPTH_C - cnt_q) >= BURST_C);
  assign src_stop  = active && (cnt_q >= (DEPTH_C - ONE_C));
  assign src_end   = (state_q == F_ERR);
  assign dst_start = (in_run && (cnt_q >= BURST_C)) || (in_drain && !empty);
  assign dst_stop  = active && (cnt_q <= ONE_C) && !(in_drain && (cnt_q == ONE_C));
  assign dst_end   = (state_q == F_DONE) || (state_q == F_ERR);
  assign job_done  = dst_end;

  assign fifo_cnt = cnt_q;
  assign xfer_cnt = xfer_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ss_xfer_fifo.sv
// Bench for ss_xfer_fifo: directed job scenarios plus randomized jobs, compared each cycle
// against a queue-based model of the job phases.
module tb_ss_xfer_fifo;

  localparam int AW    = 4;
  localparam int BURST = 8;
  localparam int DEPTH = 1 << AW;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        go = 1'b0, ss_done = 1'b0;
  logic        src_xfer = 1'b0, src_last = 1'b0;
  logic [31:0] src_dat_lo = '0, src_dat_hi = '0;
  logic        dst_xfer = 1'b0, dst_last = 1'b0;
  logic        src_start, src_stop, src_end, dst_start, dst_stop, dst_end, job_done;
  logic [31:0] dst_dat_lo, dst_dat_hi;
  logic [AW:0] fifo_cnt;
  logic [15:0] xfer_cnt;
  logic [1:0]  err;
  logic [5:0]  hs;

  assign hs = {src_start, src_stop, src_end, dst_start, dst_stop, dst_end};

  ss_xfer_fifo #(.AW(AW), .BURST(BURST)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .go(go), .ss_done(ss_done),
    .src_xfer(src_xfer), .src_last(src_last), .src_dat_lo(src_dat_lo), .src_dat_hi(src_dat_hi),
    .src_start(src_start), .src_stop(src_stop), .src_end(src_end),
    .dst_xfer(dst_xfer), .dst_last(dst_last), .dst_dat_lo(dst_dat_lo), .dst_dat_hi(dst_dat_hi),
    .dst_start(dst_start), .dst_stop(dst_stop), .dst_end(dst_end),
    .fifo_cnt(fifo_cnt), .xfer_cnt(xfer_cnt), .job_done(job_done), .err(err)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: the FIFO is a queue, the job is a phase.
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE, P_ERR} phase_t;
  phase_t      m_ph = P_IDLE;
  logic [63:0] m_q[$];
  logic [1:0]  m_err = '0;
  logic [15:0] m_xfer = '0;

  task automatic model_reset();
    m_ph = P_IDLE; m_q.delete(); m_err = '0; m_xfer = '0;
  endtask

  task automatic model_step(input bit g, dn, sx, sl, input logic [63:0] sd, input bit dx, dl);
    bit bad;
    bad = 0;
    case (m_ph)
      P_IDLE: if (g) begin m_ph = P_RUN; m_q.delete(); m_err = '0; m_xfer = '0; end
      P_RUN, P_DRAIN: begin
        if (dn) begin
          m_ph = P_IDLE; m_q.delete(); m_err = '0;
        end else begin
          if (dx) begin
            if (m_q.size() == 0) bad = 1;
            else begin void'(m_q.pop_front()); m_xfer = m_xfer + 16'd1; end
          end
          if (sx && m_ph == P_RUN) begin
            if (m_q.size() < DEPTH) m_q.push_back(sd);
            else bad = 1;
          end
          if (bad) begin
            m_err[0] = 1'b1; m_ph = P_ERR;
          end else if (m_ph == P_RUN) begin
            if (dx && dl) begin m_err[1] = 1'b1; m_ph = P_ERR; end
            else if (sx && sl) m_ph = P_DRAIN;
          end else begin
            if (sx) begin m_err[1] = 1'b1; m_ph = P_ERR; end
            else if (dx && dl) begin
              if (m_q.size() == 0) m_ph = P_DONE;
              else begin m_err[1] = 1'b1; m_ph = P_ERR; end
            end else if (!dx && m_q.size() == 0) begin
              m_err[1] = 1'b1; m_ph = P_DONE;
            end
          end
        end
      end
      default: if (dn) begin m_ph = P_IDLE; m_q.delete(); m_err = '0; end
    endcase
  endtask

  task automatic check_outputs(input string tag);
    int c;
    bit run, drn;
    logic [5:0] e_hs;
    c   = m_q.size();
    run = (m_ph == P_RUN);
    drn = (m_ph == P_DRAIN);
    e_hs = {run && (DEPTH - c >= BURST),
            (run || drn) && (c >= DEPTH - 1),
            m_ph == P_ERR,
            (run && c >= BURST) || (drn && c != 0),
            (run || drn) && (c <= 1) && !(drn && c == 1),
            m_ph == P_DONE || m_ph == P_ERR};
    check({tag, ":cnt"}, fifo_cnt, c);
    check({tag, ":hs"}, hs, e_hs);
    check({tag, ":head"}, {dst_dat_hi, dst_dat_lo}, (c != 0) ? m_q[0] : 64'd0);
    check({tag, ":err"}, err, m_err);
    check({tag, ":xfer"}, xfer_cnt, m_xfer);
    check({tag, ":done"}, job_done, (m_ph == P_DONE || m_ph == P_ERR));
  endtask

  // One clock: check registered outputs, drive inputs, advance DUT and model together.
  task automatic cyc(input string tag, input bit g, dn, sx, sl, input logic [63:0] sd, input bit dx, dl);
    check_outputs(tag);
    go = g; ss_done = dn; src_xfer = sx; src_last = sl;
    {src_dat_hi, src_dat_lo} = sd; dst_xfer = dx; dst_last = dl;
    @(posedge wb_clk_i);
    model_step(g, dn, sx, sl, sd, dx, dl);
    #1;
    go = 0; ss_done = 0; src_xfer = 0; src_last = 0; dst_xfer = 0; dst_last = 0;
  endtask

  initial begin
    int len, pushes, pops;
    bit inject, sx, sl, dx, dl, dn, g;

    repeat (2) @(posedge wb_clk_i);
    #1;
    check_outputs("reset");
    wb_rst_i = 0;

    // Fill to full with no pops, then overflow.
    cyc("go1", 1, 0, 0, 0, 0, 0, 0);
    for (int n = 1; n <= DEPTH; n++) begin
      cyc("fill", 0, 0, 1, 0, 64'(n), 0, 0);
      if (n == 8)  check("src_start_at8", src_start, 1'b1);
      if (n == 9)  check("src_start_at9", src_start, 1'b0);
      if (n == 14) check("src_stop_at14", src_stop, 1'b0);
      if (n == 15) check("src_stop_at15", src_stop, 1'b1);
      if (n == 16) check("full_cnt", fifo_cnt, 5'd16);
    end
    check("full_noerr", err, 2'b00);
    cyc("ovf", 0, 0, 1, 0, 64'hDEAD, 0, 0);
    check("ovf_err", err, 2'b01);
    check("ovf_src_end", src_end, 1'b1);
    check("ovf_job_done", job_done, 1'b1);
    cyc("ack1", 0, 1, 0, 0, 0, 0, 0);
    check("ack_err", err, 2'b00);
    check("ack_idle_hs", hs, 6'b0);

    // Ten beats in, ten out, in order.
    cyc("go2", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) cyc("push10", 0, 0, 1, (i == 10), 64'(i), 0, 0);
    for (int i = 1; i <= 10; i++) begin
      check("fwft_order", {dst_dat_hi, dst_dat_lo}, 64'(i));
      cyc("pop10", 0, 0, 0, 0, 0, 1, (i == 10));
    end
    check("done_flag", job_done, 1'b1);
    check("done_err", err, 2'b00);
    check("done_xfer", xfer_cnt, 16'd10);
    check("done_dst_end", dst_end, 1'b1);
    cyc("ack2", 0, 1, 0, 0, 0, 0, 0);

    // Destination chain longer than source: drain empties without dst_last.
    cyc("go3", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 4; i++) cyc("push4", 0, 0, 1, (i == 4), 64'(i * 3), 0, 0);
    for (int i = 1; i <= 4; i++) cyc("pop4", 0, 0, 0, 0, 0, 1, 0);
    cyc("drain_empty", 0, 0, 0, 0, 0, 0, 0);
    check("long_err", err, 2'b10);
    check("long_dst_end", dst_end, 1'b1);
    check("long_done", job_done, 1'b1);
    cyc("ack3", 0, 1, 0, 0, 0, 0, 0);

    // Full FIFO streaming: push and pop together for 32 cycles.
    cyc("go4", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) cyc("fill4", 0, 0, 1, 0, 64'h100 + 64'(i), 0, 0);
    for (int k = 0; k < 32; k++) begin
      check("stream_head", {dst_dat_hi, dst_dat_lo}, (k < DEPTH) ? 64'h100 + 64'(k) : 64'h200 + 64'(k - DEPTH));
      cyc("stream", 0, 0, 1, 0, 64'h200 + 64'(k), 1, 0);
      check("stream_cnt", fifo_cnt, 5'd16);
    end
    check("stream_err", err, 2'b00);
    cyc("abort4", 0, 1, 0, 0, 0, 0, 0);

    // Reset mid-job with five beats held.
    cyc("go5", 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc("push5", 0, 0, 1, 0, 64'hA0 + 64'(i), 0, 0);
    check("pre_rst_cnt", fifo_cnt, 5'd5);
    wb_rst_i = 1;
    #1;
    check("rst_cnt", fifo_cnt, 5'd0);
    check("rst_hs", hs, 6'b0);
    check("rst_done", job_done, 1'b0);
    model_reset();
    @(posedge wb_clk_i);
    #1;
    check_outputs("rst_hold");
    wb_rst_i = 0;

    // Randomized jobs with occasional injected protocol errors and aborts.
    for (int j = 0; j < 40; j++) begin
      len    = $urandom_range(1, 40);
      pushes = 0;
      pops   = 0;
      inject = ($urandom_range(0, 7) == 0);
      cyc("rgo", 1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 300; k++) begin
        if (m_ph == P_DONE || m_ph == P_ERR || m_ph == P_IDLE) break;
        dx = (pops < len) && (m_q.size() > 0) && ($urandom_range(0, 2) != 0);
        if (inject && $urandom_range(0, 15) == 0) dx = 1;
        sx = (pushes < len) && ($urandom_range(0, 1) == 1) && (m_q.size() < DEPTH || dx || inject);
        sl = sx && (pushes == len - 1);
        dl = dx && (pops == len - 1);
        dn = ($urandom_range(0, 399) == 0);
        g  = ($urandom_range(0, 49) == 0);
        cyc("rand", g, dn, sx, sl, {$urandom, $urandom}, dx, dl);
        if (sx) pushes++;
        if (dx) pops++;
      end
      cyc("rend", 0, 1, 0, 0, 0, 0, 0);
    end
    check_outputs("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
